skinny_sbox_inv_layer: RTL

//   Inverse SKINNY-64 S-box layer: applies S4^-1 to all 16 nibbles of a 64-bit state.

---
 rtl/skinny_sbox_inv_layer_if.sv | 28 ++
 rtl/skinny_sbox_inv_layer.sv | 96 +++++++++
 2 files changed

// File: rtl/skinny_sbox_inv_layer_if.sv
// Valid/ready bundle for the inverse SKINNY-64 S-box layer.
// The slave side is the S-box block; the master side feeds states in and takes results out.
interface skinny_sbox_inv_layer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_state;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_state;

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );
endinterface

// File: rtl/skinny_sbox_inv_layer.sv
// Inverse SKINNY-64 S-box layer: applies S4^-1 to all 16 nibbles, NIB_PER_CYC nibbles per cycle.
// Each S4^-1 lane is a flat AND/XOR/INV network so the layer can be masked gate by gate.
module skinny_sbox_inv_layer #(
    parameter int NIB_PER_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    skinny_sbox_inv_layer_if.slave bus,
    output logic                   busy
);
    localparam int STATE_W = 64;
    localparam int NUM_GRP = 16 / NIB_PER_CYC;
    localparam int CNT_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GRP - 1);

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t             state;
    logic [STATE_W-1:0] work;
    logic [STATE_W-1:0] work_sub;
    logic [STATE_W-1:0] result;
    logic [CNT_W-1:0]   cnt;
    logic               in_ready;
    logic               out_valid;

    // Algebraic normal form of S4^-1 with input bits a3..a0 (a3 = MSB).
    function automatic logic [3:0] sbox_inv(input logic [3:0] a);
        logic [3:0] y;
        y[0] = ~(a[0] ^ a[1] ^ (a[0] & a[1])) ^ a[2] ^ (a[0] & a[2]) ^ (a[1] & a[3])
             ^ (a[0] & a[2] & a[3]) ^ (a[1] & a[2] & a[3]);
        y[1] = a[0] ^ ~(a[2] ^ a[3] ^ (a[2] & a[3]));
        y[2] = a[1] ^ ((a[0] ^ a[2]) & ~a[3]);
        y[3] = (a[0] & a[1]) ^ a[2] ^ (a[1] & a[2]) ^ a[3] ^ (a[0] & a[3]) ^ (a[1] & a[3])
             ^ (a[1] & a[2] & a[3]);
        return y;
    endfunction

    // Only the nibbles belonging to the group selected by cnt are substituted this cycle.
    for (genvar i = 0; i < 16; i++) begin : g_nib
        localparam int GRP = i / NIB_PER_CYC;
        assign work_sub[4*i +: 4] = (cnt == CNT_W'(GRP)) ? sbox_inv(work[4*i +: 4])
                                                         : work[4*i +: 4];
    end

    // result is a separate register so out_state holds after the handshake while work is reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            result    <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready) begin
                        work     <= bus.in_state;
                        cnt      <= '0;
                        state    <= PROC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                PROC: begin
                    work <= work_sub;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_GRP) begin
                        result    <= work_sub;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_state = result;
endmodule
